// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants and capture state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Segment order is bit6..bit0 = a,b,c,d,e,f,g, active-low; the display encoder uses the same table.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } cap_state_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational decode of an active-low segment pattern back to BCD.
// Latency: 0 cycles. Backpressure: none (pure function).
// Ports: seg_n[6:0] in; value[3:0], valid (0-9 decoded), err (undefined pattern) out.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       valid,
  output logic       err
);

  always_comb begin
    value = DIGIT_ERR;
    valid = 1'b1;
    err   = 1'b0;
    case (seg_n)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: begin
        value = DIGIT_BLANK;
        valid = 1'b0;
      end
      default: begin
        value = DIGIT_ERR;
        valid = 1'b0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Passive monitor rebuilding displayed digits from a multiplexed active-low 7-seg drive.
// Latency: inputs constant from edge k -> update/digits visible after edge k+STABLE_CYCLES+1.
// Backpressure: none; observes the bus only, outputs are registered pulses/levels.
// Ports: clk, reset (sync, active-high), seg_n[6:0], dig_sel[NUM_DIGITS-1:0] in;
//        digits[4*NUM_DIGITS-1:0], valid, err, update, frame_done out.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

  // Sample register S and previous sample P.
  logic [6:0]            s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic [NUM_DIGITS-1:0] s_sel_q, s_sel_d, p_sel_q, p_sel_d;

  cap_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    update_q, update_d;
  logic                    frame_done_q, frame_done_d;

  logic [3:0] dec_value;
  logic       dec_valid;
  logic       dec_err;

  logic                  same;
  logic                  s_onehot;
  logic                  wr;
  logic [NUM_DIGITS-1:0] mask_next;

  // The write always uses P: when the count completes, P holds the pattern
  // that has been stable for STABLE_CYCLES samples, even if S just moved.
  sevenseg_decode u_decode (
    .seg_n (p_seg_q),
    .value (dec_value),
    .valid (dec_valid),
    .err   (dec_err)
  );

  always_comb begin
    s_seg_d = seg_n;
    s_sel_d = dig_sel;
    p_seg_d = s_seg_q;
    p_sel_d = s_sel_q;

    same     = (s_seg_q == p_seg_q) && (s_sel_q == p_sel_q);
    s_onehot = (s_sel_q != '0) &&
               ((s_sel_q & (s_sel_q - NUM_DIGITS'(1))) == '0);

    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    update_d     = 1'b0;
    frame_done_d = 1'b0;
    wr           = 1'b0;
    mask_next    = mask_q;

    case (state_q)
      IDLE: begin
        if (s_onehot) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_TARGET) begin
          wr = 1'b1;
        end
        if (same && (cnt_q == CNT_TARGET)) begin
          state_d = HELD;
        end else if (same) begin
          // Only reachable below the target, so the count cannot wrap.
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = s_onehot ? SETTLE : IDLE;
          cnt_d   = s_onehot ? CNT_ONE : '0;
        end
      end
      HELD: begin
        if (!same) begin
          state_d = s_onehot ? SETTLE : IDLE;
          cnt_d   = s_onehot ? CNT_ONE : '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (wr) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (p_sel_q[i]) begin
          digits_d[4*i +: 4] = dec_value;
          valid_d[i]         = dec_valid;
          err_d[i]           = dec_err;
        end
      end
      update_d  = 1'b1;
      mask_next = mask_q | p_sel_q;
      // The completing write closes this frame and does not seed the next one.
      if (mask_next == '1) begin
        frame_done_d = 1'b1;
        mask_d       = '0;
      end else begin
        mask_d = mask_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg_q      <= SEG_BLANK;
      s_sel_q      <= '0;
      p_seg_q      <= SEG_BLANK;
      p_sel_q      <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      digits_q     <= {NUM_DIGITS{DIGIT_BLANK}};
      valid_q      <= '0;
      err_q        <= '0;
      update_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      s_seg_q      <= s_seg_d;
      s_sel_q      <= s_sel_d;
      p_seg_q      <= p_seg_d;
      p_sel_q      <= p_sel_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      update_q     <= update_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign update     = update_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture with hand-computed expectations.
// Latency: n/a. Backpressure: n/a.
// Ports: none; drives clk/reset/seg_n/dig_sel and checks all DUT outputs.
module tb_sevenseg_capture;

  localparam int NUM_DIGITS    = 4;
  localparam int STABLE_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        update;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Accumulated by step() over a phase.
  int upd_cnt;
  int fd_cnt;
  int fd_alone;
  int first_upd;
  int cyc;

  sevenseg_capture #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_n      (seg_n),
    .dig_sel    (dig_sel),
    .digits     (digits),
    .valid      (valid),
    .err        (err),
    .update     (update),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    upd_cnt   = 0;
    fd_cnt    = 0;
    fd_alone  = 0;
    first_upd = 0;
    cyc       = 0;
  endtask

  // Advance n cycles, sampling outputs 1ns after each rising edge.
  // cyc counts edges since clear_counts(), the first edge being 1.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (update) begin
        upd_cnt++;
        if (first_upd == 0) first_upd = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        if (!update) fd_alone++;
      end
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
    dig_sel = sel;
    seg_n   = seg;
  endtask

  initial begin
    reset   = 1'b1;
    seg_n   = 7'b1111111;
    dig_sel = 4'b0000;
    clear_counts();
    step(3);

    // Reset values.
    chk("rst_digits", 32'(digits), 32'h0000FFFF);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    reset = 1'b0;
    step(2);

    // Single digit 5 on position 0. Inputs first sampled at edge 1, so the
    // write lands on edge STABLE_CYCLES+2 of this count.
    clear_counts();
    drive(4'b0001, 7'b0100100);
    step(20);
    chk("t1_first_update", 32'(first_upd), 32'(STABLE_CYCLES + 2));
    chk("t1_update_count", 32'(upd_cnt), 32'd1);
    chk("t1_digit0", 32'(digits[3:0]), 32'h5);
    chk("t1_valid", 32'(valid), 32'b0001);
    chk("t1_err", 32'(err), 32'h0);

    // Scan 1,2,3,4 across digits 0..3; digit 0 was already seen above.
    clear_counts();
    drive(4'b0001, 7'b1001111); step(12);
    drive(4'b0010, 7'b0010010); step(12);
    drive(4'b0100, 7'b0000110); step(12);
    drive(4'b1000, 7'b1001100); step(12);
    drive(4'b0000, 7'b1111111); step(4);
    chk("scan_update_count", 32'(upd_cnt), 32'd4);
    chk("scan_frame_done_count", 32'(fd_cnt), 32'd1);
    chk("scan_frame_done_without_update", 32'(fd_alone), 32'd0);
    chk("scan_digits", 32'(digits), 32'h4321);
    chk("scan_valid", 32'(valid), 32'b1111);
    chk("scan_err", 32'(err), 32'h0);

    // Short glitch: 7 samples on digit 2, then bus released.
    clear_counts();
    drive(4'b0100, 7'b0000000); step(7);
    drive(4'b0000, 7'b1111111); step(15);
    chk("glitch_update_count", 32'(upd_cnt), 32'd0);
    chk("glitch_digits", 32'(digits), 32'h4321);

    // Multi-hot select never writes.
    clear_counts();
    drive(4'b0011, 7'b0000000); step(30);
    chk("multihot_update_count", 32'(upd_cnt), 32'd0);
    chk("multihot_digits", 32'(digits), 32'h4321);

    // Blank pattern on digit 2.
    clear_counts();
    drive(4'b0100, 7'b1111111); step(12);
    chk("blank_update_count", 32'(upd_cnt), 32'd1);
    chk("blank_frame_done_count", 32'(fd_cnt), 32'd0);
    chk("blank_digits", 32'(digits), 32'h4F21);
    chk("blank_valid", 32'(valid), 32'b1011);
    chk("blank_err", 32'(err), 32'h0);

    // Undefined pattern on digit 0.
    clear_counts();
    drive(4'b0001, 7'b1010101); step(12);
    chk("bad_update_count", 32'(upd_cnt), 32'd1);
    chk("bad_digits", 32'(digits), 32'h4F2E);
    chk("bad_valid", 32'(valid), 32'b1010);
    chk("bad_err", 32'(err), 32'b0001);

    // Reset in the middle of settling on digit 1.
    clear_counts();
    drive(4'b0010, 7'b0001111); step(5);
    chk("midsettle_no_update", 32'(upd_cnt), 32'd0);
    reset = 1'b1;
    step(1);
    chk("midrst_digits", 32'(digits), 32'h0000FFFF);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_update", 32'(update), 32'h0);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);

    // After release with an idle bus, the discarded count must not complete.
    reset = 1'b0;
    drive(4'b0000, 7'b1111111);
    clear_counts();
    step(15);
    chk("post_rst_update_count", 32'(upd_cnt), 32'd0);
    chk("post_rst_digits", 32'(digits), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
